// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe
// Description : Chain of DEPTH two-entry skid-buffer slices carrying DW-bit
//               words under a valid/ready handshake. It gives registered
//               backpressure, full throughput, synchronous flush and a
//               configurable data reset value. in_ready comes straight from
//               a flop, so it has no combinational path from out_ready.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               flush      synchronous clear of every valid bit and occupancy
//               in_valid   upstream word valid
//               in_data    upstream word (DW bits)
//               in_ready   slice 0 can accept (registered)
//               out_valid  last slice main register holds a word
//               out_data   last slice main register data
//               out_ready  downstream accepts
//               occupancy  registered count of buffered words, 0..2*DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe #(
    parameter int            DW      = 32,
    parameter int            DEPTH   = 2,
    parameter logic [DW-1:0] RST_VAL = '0,
    parameter int            OW      = $clog2(2*DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [OW-1:0] occupancy
);

    // Inter-slice links. Index k is the input side of slice k; index DEPTH
    // is the pipeline output. Valid/data flow forward, ready flows backward.
    logic [DEPTH:0]  w_vld;
    logic [DEPTH:0]  w_rdy;
    logic [DW-1:0]   w_dat [DEPTH+1];

    assign w_vld[0]     = in_valid;
    assign w_dat[0]     = in_data;
    assign w_rdy[DEPTH] = out_ready;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_slice
            logic          r_m_valid;
            logic [DW-1:0] r_m_data;
            logic          r_s_valid;
            logic [DW-1:0] r_s_data;
            logic          w_in_fire;
            logic          w_out_fire;

            // Ready depends only on this slice's own skid flop.
            assign w_rdy[k]   = ~r_s_valid;
            assign w_vld[k+1] = r_m_valid;
            assign w_dat[k+1] = r_m_data;

            assign w_in_fire  = w_vld[k] & ~r_s_valid;
            assign w_out_fire = r_m_valid & w_rdy[k+1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= RST_VAL;
                    r_s_valid <= 1'b0;
                    r_s_data  <= RST_VAL;
                end else if (flush) begin
                    // Data registers keep their contents; only validity drops.
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                end else if (r_s_valid && w_out_fire) begin
                    // Skid entry moves up; ready was low so no input fires.
                    r_m_data  <= r_s_data;
                    r_s_valid <= 1'b0;
                end else if (w_in_fire && r_m_valid && !w_out_fire) begin
                    // Main is stuck: park the incoming word in the skid slot.
                    r_s_data  <= w_dat[k];
                    r_s_valid <= 1'b1;
                end else if (w_in_fire) begin
                    r_m_data  <= w_dat[k];
                    r_m_valid <= 1'b1;
                end else if (w_out_fire) begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign in_ready  = w_rdy[0];
    assign out_valid = w_vld[DEPTH];
    assign out_data  = w_dat[DEPTH];

    // Occupancy tracks boundary handshakes only; transfers between slices
    // do not change the number of words held.
    logic          w_in_fire0;
    logic          w_out_fire_last;
    logic [OW-1:0] r_occ;

    assign w_in_fire0      = in_valid & in_ready;
    assign w_out_fire_last = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_fire0 && !w_out_fire_last) begin
            r_occ <= r_occ + OW'(1);
        end else if (!w_in_fire0 && w_out_fire_last) begin
            r_occ <= r_occ - OW'(1);
        end
    end

    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_pipe
// Description : Self-checking bench for elastic_pipe (DW=8, DEPTH=2,
//               RST_VAL=0x5A). A cycle table covers latency, fill/drain and
//               flush; a negedge monitor holds a scoreboard queue of accepted
//               words and checks order and occupancy every cycle; hand-written
//               sequences cover throughput, random traffic and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe;

    localparam int            c_dw    = 8;
    localparam int            c_depth = 2;
    localparam logic [7:0]    c_rst   = 8'h5A;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] occupancy;

    elastic_pipe #(
        .DW      (c_dw),
        .DEPTH   (c_depth),
        .RST_VAL (c_rst)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int n_out  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: words accepted at the input, in order.
    logic [7:0] sb [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("occ_vs_model", int'(occupancy), sb.size());
            chk("occ_bound", int'(occupancy <= 3'd4), 1);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) chk("unexpected_out", int'(out_data), -1);
                else chk("out_order", int'(out_data), int'(sb.pop_front()));
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    // Cycle table: inputs driven just after the edge, outputs checked at negedge.
    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       eir;
        logic       eov;
        logic [7:0] eod;
        logic [2:0] eocc;
    } vec_t;

    vec_t tbl [22];

    task automatic push_words(input int n, input logic [7:0] base);
        int   idx   = 0;
        int   guard = 0;
        logic fired;
        in_valid = 1'b1;
        in_data  = base;
        while (idx < n && guard < 1000) begin
            @(negedge clk);
            fired = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (fired) begin
                idx++;
                in_data = base + 8'(idx);
            end
        end
        in_valid = 1'b0;
        chk("push_count", idx, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, iters, outs, bad, n0;
        logic fired;

        //            iv    d      ordy  fl    eir   eov   eod    eocc
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 3'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 3'd1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0};
        tbl[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0};
        tbl[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd1};
        tbl[6]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2};
        tbl[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3};
        tbl[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
        tbl[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
        tbl[10] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
        tbl[11] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 3'd3};
        tbl[12] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 3'd2};
        tbl[13] = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 3'd2};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 3'd1};
        tbl[16] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 3'd0};
        tbl[17] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 3'd1};
        tbl[18] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
        tbl[19] = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3'd3};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 3'd0};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 3'd0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- table: latency, fill/release, flush while partly full ----
        for (int i = 0; i < 22; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("row%0d_in_ready", i),  int'(in_ready),  int'(tbl[i].eir));
            chk($sformatf("row%0d_out_valid", i), int'(out_valid), int'(tbl[i].eov));
            chk($sformatf("row%0d_out_data", i),  int'(out_data),  int'(tbl[i].eod));
            chk($sformatf("row%0d_occupancy", i), int'(occupancy), int'(tbl[i].eocc));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        // ---- throughput: 64 words back to back ----
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        idx = 0; iters = 0; outs = 0; bad = 0;
        n0  = n_out;
        while (idx < 64 && iters < 200) begin
            @(negedge clk);
            fired = in_valid && in_ready;
            if (out_valid) outs++;
            if (idx >= 2 && occupancy != 3'd2) bad++;
            iters++;
            @(posedge clk); #1;
            if (fired) begin
                idx++;
                in_data = 8'(idx);
            end
        end
        in_valid = 1'b0;
        chk("tp_input_cycles", iters, 64);
        chk("tp_outputs_during_stream", outs, 62);
        chk("tp_occ_steady_violations", bad, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("tp_tail_out_valid", int'(out_valid), 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tp_total_out", n_out - n0, 64);
        chk("tp_empty_after", int'(out_valid), 0);
        @(posedge clk); #1;

        // ---- random traffic with occasional flush ----
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            fired = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || fired) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rand_drain_sb_empty", sb.size(), 0);
        chk("rand_drain_occ", int'(occupancy), 0);
        @(posedge clk); #1;

        // ---- fill to capacity, then asynchronous reset mid-stream ----
        out_ready = 1'b0;
        push_words(4, 8'hC0);
        @(negedge clk);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_occ", int'(occupancy), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), int'(c_rst));
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_occ", int'(occupancy), 0);
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        n0 = n_out;
        push_words(3, 8'h70);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("resume_out_count", n_out - n0, 3);
        chk("resume_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised elastic pipeline of DEPTH register slices carrying DW-bit data under a valid/ready handshake. It replaces bare load-enabled flip-flops wherever a core datapath stage needs registered backpressure, full throughput, pipeline flush and a configurable reset value. Each slice is a two-entry skid buffer, so `in_ready` is always a registered signal and never a combinational path from `out_ready`.

## Interface
- `DW`, 32: data width, at least 1
- `DEPTH`, 2: number of slices, at least 1
- `RST_VAL`, {DW{1'b0}}: reset value of every data register
- `OW`, $clog2(2*DEPTH+1): occupancy width (derived, not overridden)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous pipeline clear
- `in_valid`  in  1  upstream data valid
- `in_data`  in  DW  upstream data
- `in_ready`  out  1  slice 0 can accept
- `out_valid`  out  1  last slice holds data
- `out_data`  out  DW  last slice main data
- `out_ready`  in  1  downstream accepts
- `occupancy`  out  OW  number of valid entries, 0..2*DEPTH

## Operation
- Each slice has a main register (`m_valid`, `m_data`) and a skid register (`s_valid`, `s_data`).
- Slice interface: `ready = !s_valid`, `valid = m_valid`, `data = m_data`. Slice k's output drives slice k+1's input.
- Per slice, define `in_fire = valid_in & ready` and `out_fire = m_valid & ready_out`. Cases, evaluated in priority order:
  - `s_valid & out_fire`: `m <= s`, `s_valid <= 0`. `in_fire` cannot occur in this case.
  - `!s_valid & in_fire & m_valid & !out_fire`: `s <= in`, `s_valid <= 1` (skid capture).
  - `!s_valid & in_fire` otherwise: `m <= in`, `m_valid <= 1`.
  - `!s_valid & !in_fire & out_fire`: `m_valid <= 0`.
  - Otherwise: hold.
- Data registers load only with their valid set. They are never cleared by flush.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush.
- `occupancy` is registered:
  - +1 on `in_fire` at slice 0.
  - −1 on `out_fire` at the last slice.
  - Unchanged when both fire in the same cycle.
- `flush = 1`:
  - All `m_valid` and `s_valid` bits go to 0 at the next edge.
  - `occupancy` goes to 0.
  - A coincident `in_fire` is discarded.
  - A coincident `out_fire` still completes downstream, since `out_valid` was high that cycle.
  - Flush has priority over every case above.
- Reset: all valid bits 0, all data registers RST_VAL, `occupancy` 0.

## Timing
- Reset values of outputs: `in_ready` 1, `out_valid` 0, `out_data` RST_VAL, `occupancy` 0. Reset is asynchronous assert and synchronous-safe release.
- Latency: a word accepted at edge t appears on `out_valid`/`out_data` after edge t+DEPTH−1, visible in cycle t+DEPTH, when there is no stall.
- Throughput: 1 word/cycle sustained while `out_ready` = 1. No bubbles.
- Capacity: 2*DEPTH words. With `out_ready` = 0, exactly 2*DEPTH words are accepted, then `in_ready` = 0.
- Backpressure release: `in_ready` reasserts within DEPTH cycles of `out_ready` rising. It is never combinational from `out_ready`.
- `in_ready` is a pure register output. `in_valid`/`in_data` may change only after a fire or while `in_valid` = 0.
- Reset mid-operation: all in-flight data is lost. Outputs take reset values immediately on `rst_n` falling.
- Flush while full: `in_ready` = 1 and `out_valid` = 0 in the cycle after the flush edge.

## Test plan
- Latency, DEPTH = 2, DW = 8, `out_ready` = 1: push 0xA5 at cycle 0 -> `out_valid` = 1 with `out_data` = 0xA5 at cycle 2, `occupancy` 1 in cycles 1–2, 0 after.
- Fill, DEPTH = 2, `out_ready` = 0: offer 0x01..0x06 continuously -> exactly 0x01..0x04 accepted, `in_ready` = 0, `occupancy` = 4. Then `out_ready` = 1 -> outputs 0x01..0x06 in order, no loss, no duplication.
- Throughput: stream 0x00..0x3F with `out_ready` = 1 -> 64 consecutive outputs, one per cycle, `occupancy` constant at 2 after fill.
- Random backpressure: random `in_valid`/`out_ready` for 10k cycles -> scoreboard order match, `occupancy` = accepted − delivered at every cycle, never above 2*DEPTH.
- Flush: occupancy 3, `flush` pulse with `in_valid` = 1 -> next cycle `out_valid` = 0, `occupancy` = 0, `in_ready` = 1, flushed and coincident words never emerge.
- Reset mid-stream, RST_VAL = 0x5A: drop `rst_n` while full -> `out_valid` = 0, `out_data` = 0x5A, `in_ready` = 1, `occupancy` = 0 immediately. Traffic resumes correctly after release.
